prog_mem_loader: RTL and testbench

Write-side companion to the instruction (program) memory: accepts a byte stream carrying a word count followed by 32-bit instruction words, assembles them little-endian, and writes them into consecutive program-memory addresses starting at 0. While loading, it holds the processor in reset. It releases the processor only after the last word is written. It sits between the host/debug byte link and the program-memory write port.

---
 rtl/prog_mem_loader_if.sv | 22 ++
 rtl/prog_mem_loader.sv | 152 +++++++++++++++
 tb/tb_prog_mem_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_if.sv
// Byte-stream link between the host/debug side and the program-memory loader.
//   byte_in    : stream byte (source -> loader)
//   byte_valid : byte_in is valid this cycle (source -> loader)
//   byte_ready : loader accepts a byte on this edge (loader -> source)
// A byte moves on a rising edge where byte_valid && byte_ready.
interface prog_mem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Program-memory loader. Takes a byte stream of the form
//   count_lo, count_hi, then count words of 4 bytes each (LSB first)
// and writes the words to program memory at addresses 0..count-1. The processor
// is held in reset (cpu_rst=1) unless a load has completed successfully.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle pulse, begins a load from idle/done/error
//   bus        : byte stream (slave side)
//   mem_we     : one-cycle write strobe per word
//   mem_addr   : word address
//   mem_wdata  : assembled instruction word
//   busy       : load in progress
//   done       : load completed (sticky until start/rst)
//   err        : header count exceeded DEPTH (sticky until start/rst)
//   cpu_rst    : processor reset request, low only after a completed load
module prog_mem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  prog_mem_loader_if.slave    bus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_rst
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  // Word count and index are one bit wider than the address so N == DEPTH
  // terminates without the index wrapping back to 0.
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       asm_q, asm_d;
  logic [15:0]       hdr_n;
  logic              accept;

  logic              byte_ready_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_q;

  assign accept = bus.byte_valid && byte_ready_q;
  assign hdr_n  = {bus.byte_in, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    count_d  = count_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    asm_d    = asm_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StHdr0;
      end
      StHdr0: begin
        if (accept) begin
          cnt_lo_d = bus.byte_in;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          count_d = hdr_n[ADDR_W:0];
          idx_d   = '0;
          bidx_d  = '0;
          if (hdr_n == 16'd0)        state_d = StDone;
          else if (hdr_n > DepthW)   state_d = StErr;
          else                       state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          asm_d[{bidx_q, 3'b000} +: 8] = bus.byte_in;
          // Index holds at 3 on the last byte; it restarts when leaving WRITE.
          if (bidx_q == 2'd3) state_d = StWrite;
          else                bidx_d  = bidx_q + 2'd1;
        end
      end
      StWrite: begin
        idx_d  = idx_q + 1'b1;
        bidx_d = '0;
        if (idx_d == count_q) state_d = StDone;
        else                  state_d = StData;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_lo_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      bidx_q       <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      bidx_q       <= bidx_d;
      asm_q        <= asm_d;
      byte_ready_q <= (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData);
      mem_we_q     <= (state_d == StWrite);
      busy_q       <= (state_d == StHdr0) || (state_d == StHdr1) ||
                      (state_d == StData) || (state_d == StWrite);
      done_q       <= (state_d == StDone);
      err_q        <= (state_d == StErr);
      cpu_rst_q    <= (state_d != StDone);
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = idx_q[ADDR_W-1:0];
  assign mem_wdata      = asm_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cpu_rst        = cpu_rst_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err, cpu_rst;

  prog_mem_loader_if bus ();

  prog_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst   (cpu_rst)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every mem_we pulse is matched against the next expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [ADDR_W+31:0] e;
      check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        check("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte and returns just after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got byte_ready 0 expected 1 within 50 cycles");
    end
    tick();
    if (gap) begin
      bus.byte_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit gap);
    exp_q.push_back({a, d});
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8], gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_mem_we"},     32'(mem_we), 32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
    check({tag, "_err"},        32'(err), 32'd0);
    check({tag, "_cpu_rst"},    32'(cpu_rst), 32'd1);
  endtask

  // Called right after the final data byte was accepted.
  task automatic finish_load(input string tag);
    check({tag, "_cpu_rst_during_write"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done_during_write"},    32'(done), 32'd0);
    bus.byte_valid = 1'b0;
    tick();
    check({tag, "_done"},    32'(done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_two(input bit gap, input string tag);
    pulse_start();
    check({tag, "_ready_hdr0"}, 32'(bus.byte_ready), 32'd1);
    send_byte(8'h02, gap);
    send_byte(8'h00, gap);
    send_word(10'd0, 32'h0010_0013, gap);
    send_word(10'd1, 32'h0020_0093, 1'b0);
    finish_load(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("idle_ignores_valid", 32'(bus.byte_ready), 32'd0);

    // Back-to-back and toggling-valid loads of the same two-word stream.
    load_two(1'b0, "n2");
    load_two(1'b1, "n2_gap");

    // Empty program: straight to done, no writes.
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.byte_valid = 1'b0;
    check("n0_done", 32'(done), 32'd1);
    check("n0_cpu_rst", 32'(cpu_rst), 32'd0);

    // N=1025 exceeds DEPTH.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    bus.byte_valid = 1'b0;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("ovf_err_sticky", 32'(err), 32'd1);
    pulse_start();
    check("ovf_restart_err", 32'(err), 32'd0);
    check("ovf_restart_busy", 32'(busy), 32'd1);
    check("ovf_restart_ready", 32'(bus.byte_ready), 32'd1);

    // Full-depth load (still in HDR0 from the restart above).
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++)
      send_word(ADDR_W'(i), 32'hC0DE_0000 | 32'(i), 1'b0);
    finish_load("n1024");

    // Reset in the middle of word 1, then a fresh one-word load.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(10'd0, 32'h1111_2222, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bus.byte_valid = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(10'd0, 32'hDEAD_BEEF, 1'b0);
    finish_load("n1");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
